// File: rtl/onewire_slave_rx.sv
// onewire_slave_rx
//   Receive-side slot decoder for the slave end of the 1-Wire link.
//
//   The decoder measures each master-driven low pulse on the open-drain bus:
//     - A short low decodes as bit 1.
//     - A long low decodes as bit 0.
//     - A low that reaches MAX_LOW is a bus reset.
//     - A low shorter than MIN_LOW is discarded as a glitch.
//   Decoded bits are assembled LSB-first into bytes. Bytes are handed to the
//   command logic through a valid/ack interface.
//
//   Optional feature, selected by the macro ONEWIRE_RX_SYNC_EN:
//     - Defined: bus_in passes through a 2-flop synchronizer. This adds
//       2 cycles of latency and leaves pulse lengths unchanged.
//     - Undefined: bus_in is used directly. Only do this when bus_in is
//       already synchronous to clk.
//
// Parameters
//   THRESH  - longest low length (cycles) still decoded as bit 1
//   MIN_LOW - lows shorter than this are glitches
//   MAX_LOW - low length at which a bus reset is declared
//             (requires THRESH < MAX_LOW < 2**CNT_W)
//   CNT_W   - low-length counter width
//
// Ports
//   clk        in   system clock
//   rst        in   asynchronous active-high reset
//   bus_in     in   1-Wire bus level, idle high
//   bit_valid  out  one-cycle pulse: a decoded bit is available
//   bit_data   out  decoded bit value, held until the next bit_valid
//   byte_valid out  level: byte_data holds a complete byte
//   byte_data  out  assembled byte, first received bit in [0]
//   byte_ack   in   consumer accepts the byte (sampled while byte_valid=1)
//   overrun    out  one-cycle pulse: an unacked byte was overwritten
//   glitch     out  one-cycle pulse: a too-short low was discarded
//   bus_reset  out  one-cycle pulse: the low reached MAX_LOW
module onewire_slave_rx #(
    parameter int THRESH  = 30,
    parameter int MIN_LOW = 2,
    parameter int MAX_LOW = 120,
    parameter int CNT_W   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bus_in,
    output logic       bit_valid,
    output logic       bit_data,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    input  logic       byte_ack,
    output logic       overrun,
    output logic       glitch,
    output logic       bus_reset
);

    localparam logic [CNT_W:0]   MAX_CNT = (CNT_W+1)'(MAX_LOW);
    localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_LOW);
    localparam logic [CNT_W-1:0] THR_CNT = CNT_W'(THRESH);

    typedef enum logic [1:0] {IDLE, LOW, BRST} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;
    logic [7:0]       sr;
    logic             s;

`ifdef ONEWIRE_RX_SYNC_EN
    logic sync_p0;
    logic sync_p1;

    // Synchronizer stage: both flops reset to the idle-high bus level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
        end else begin
            sync_p0 <= bus_in;
            sync_p1 <= sync_p0;
        end
    end

    assign s = sync_p1;
`else
    assign s = bus_in;
`endif

    // The counter is widened by one bit so that the MAX_LOW comparison
    // cannot alias on wrap.
    logic [CNT_W:0] cnt_inc;
    logic           low_end;
    logic           is_glitch;
    logic           dec_bit;
    logic [7:0]     sr_next;

    assign cnt_inc   = {1'b0, cnt} + (CNT_W+1)'(1);
    assign low_end   = (state == LOW) && s;
    assign is_glitch = (cnt < MIN_CNT);
    assign dec_bit   = (cnt <= THR_CNT);

    // Shift register with the bit being decoded already placed at idx.
    // This lets the 8th bit complete byte_data on the same edge.
    always_comb begin
        sr_next      = sr;
        sr_next[idx] = dec_bit;
    end

    // Decode stage: slot FSM, byte assembly and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            sr         <= '0;
            bit_valid  <= 1'b0;
            bit_data   <= 1'b0;
            byte_valid <= 1'b0;
            byte_data  <= '0;
            overrun    <= 1'b0;
            glitch     <= 1'b0;
            bus_reset  <= 1'b0;
        end else begin
            bit_valid <= 1'b0;
            overrun   <= 1'b0;
            glitch    <= 1'b0;
            bus_reset <= 1'b0;

            // Ack releases the byte; a byte completing this same edge
            // overrides this below and keeps byte_valid high.
            if (byte_valid && byte_ack) begin
                byte_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (!s) begin
                        state <= LOW;
                        cnt   <= CNT_W'(1);
                    end
                end

                LOW: begin
                    if (!s) begin
                        cnt <= cnt_inc[CNT_W-1:0];
                        if (cnt_inc == MAX_CNT) begin
                            state     <= BRST;
                            bus_reset <= 1'b1;
                            sr        <= '0;
                            idx       <= '0;
                        end
                    end else if (low_end) begin
                        state <= IDLE;
                        if (is_glitch) begin
                            glitch <= 1'b1;
                        end else begin
                            bit_valid <= 1'b1;
                            bit_data  <= dec_bit;
                            if (idx == 3'd7) begin
                                byte_data  <= sr_next;
                                byte_valid <= 1'b1;
                                // An ack on this same edge hands over the
                                // old byte, so nothing is lost.
                                overrun    <= byte_valid && !byte_ack;
                                sr         <= '0;
                                idx        <= '0;
                            end else begin
                                sr  <= sr_next;
                                idx <= idx + 3'd1;
                            end
                        end
                    end
                end

                BRST: begin
                    if (s) begin
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_onewire_slave_rx.sv
// tb_onewire_slave_rx
//   Directed bench for onewire_slave_rx.
//
//   Inputs are driven on the falling clock edge. Outputs are sampled 1 time
//   unit after the rising edge by a monitor, which counts the pulses and
//   timestamps them with the rising-edge count.
//
//   The decode latency depends on whether ONEWIRE_RX_SYNC_EN is defined.
module tb_onewire_slave_rx;

`ifdef ONEWIRE_RX_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       bus_in;
    logic       byte_ack;
    logic       bit_valid;
    logic       bit_data;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       overrun;
    logic       glitch;
    logic       bus_reset;

    onewire_slave_rx #(
        .THRESH (30),
        .MIN_LOW(2),
        .MAX_LOW(120),
        .CNT_W  (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus_in    (bus_in),
        .bit_valid (bit_valid),
        .bit_data  (bit_data),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .byte_ack  (byte_ack),
        .overrun   (overrun),
        .glitch    (glitch),
        .bus_reset (bus_reset)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor: pulse counters and rising-edge timestamps.
    int   cyc           = 0;
    int   bv_cnt        = 0;
    int   last_bv_cyc   = 0;
    int   byte_rise_cyc = 0;
    int   ovr_cnt       = 0;
    int   ovr_cyc       = 0;
    int   glitch_cnt    = 0;
    int   glitch_cyc    = 0;
    int   brst_cnt      = 0;
    int   brst_cyc      = 0;
    logic prev_bv       = 1'b0;
    logic bits_q[$];

    always @(posedge clk) begin
        cyc++;
        #1;
        if (bit_valid) begin
            bv_cnt++;
            last_bv_cyc = cyc;
            bits_q.push_back(bit_data);
        end
        if (byte_valid && !prev_bv) byte_rise_cyc = cyc;
        prev_bv = byte_valid;
        if (overrun) begin
            ovr_cnt++;
            ovr_cyc = cyc;
        end
        if (glitch) begin
            glitch_cnt++;
            glitch_cyc = cyc;
        end
        if (bus_reset) begin
            brst_cnt++;
            brst_cyc = cyc;
        end
    end

    int low_cyc = 0;
    int rel_cyc = 0;

    // Drive a low of n cycles, then high for gap cycles. Called at a falling edge.
    task automatic slot(input int n, input int gap);
        low_cyc = cyc;
        bus_in  = 1'b0;
        repeat (n) @(negedge clk);
        rel_cyc = cyc;
        bus_in  = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        slot(b ? 6 : 60, 1);
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) send_bit(v[i]);
    endtask

    task automatic settle();
        repeat (5) @(negedge clk);
    endtask

    task automatic ack_byte(input string tag);
        byte_ack = 1'b1;
        @(posedge clk);
        #1;
        check(tag, byte_valid, 1'b0);
        @(negedge clk);
        byte_ack = 1'b0;
    endtask

    function automatic logic [7:0] rx_byte(input int base);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r[i] = bits_q[base + i];
        return r;
    endfunction

    int base;
    int c0;
    int g_rel;
    int brst_low;

    initial begin
        rst      = 1'b1;
        bus_in   = 1'b1;
        byte_ack = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {bit_valid, bit_data, byte_valid, byte_data, overrun, glitch, bus_reset}, 0);
        rst = 1'b0;
        @(negedge clk);

        // Bit decode and boundaries: 6->1, 60->0, 30->1, 31->0, 2->1, 119->0,
        // then 0, 0. The resulting byte is 0x15.
        base = bv_cnt;
        c0   = brst_cnt;
        slot(6, 1);
        slot(60, 1);
        settle();
        check("bit_count_2", bv_cnt - base, 2);
        check("bit_6cyc", bits_q[base], 1'b1);
        check("bit_60cyc", bits_q[base + 1], 1'b0);
        check("bit_latency", last_bv_cyc - rel_cyc, LAT);
        check("bit_data_held", bit_data, 1'b0);
        slot(30, 1);
        slot(31, 1);
        slot(2, 1);
        slot(119, 1);
        send_bit(1'b0);
        send_bit(1'b0);
        settle();
        check("bound_bits", rx_byte(base), 8'h15);
        check("bound_byte", byte_data, 8'h15);
        check("bound_no_busreset", brst_cnt - c0, 0);
        ack_byte("bound_ack");

        // Byte assembly 0xA5.
        base = bv_cnt;
        c0   = ovr_cnt;
        send_byte(8'hA5);
        settle();
        check("a5_bits", rx_byte(base), 8'hA5);
        check("a5_byte_data", byte_data, 8'hA5);
        check("a5_byte_valid", byte_valid, 1'b1);
        check("a5_rise_with_8th", byte_rise_cyc - last_bv_cyc, 0);
        check("a5_no_overrun", ovr_cnt - c0, 0);
        ack_byte("a5_ack");

        // Overrun: 0x3C, then 0xC3 with no ack.
        c0 = ovr_cnt;
        send_byte(8'h3C);
        settle();
        check("ovr_first", byte_data, 8'h3C);
        send_byte(8'hC3);
        settle();
        check("ovr_count", ovr_cnt - c0, 1);
        check("ovr_at_16th", ovr_cyc - last_bv_cyc, 0);
        check("ovr_byte_data", byte_data, 8'hC3);
        check("ovr_byte_valid", byte_valid, 1'b1);
        ack_byte("ovr_ack");

        // Glitch inside a byte: 0x5A with a 1-cycle low after bit 2.
        base = bv_cnt;
        c0   = glitch_cnt;
        for (int i = 0; i < 3; i++) send_bit(1'(8'h5A >> i));
        slot(1, 1);
        g_rel = rel_cyc;
        for (int i = 3; i < 8; i++) send_bit(1'(8'h5A >> i));
        settle();
        check("glitch_count", glitch_cnt - c0, 1);
        check("glitch_latency", glitch_cyc - g_rel, LAT);
        check("glitch_bit_count", bv_cnt - base, 8);
        check("glitch_byte", byte_data, 8'h5A);

        // Bus reset after 3 bits; the 0x5A byte is left unacked across it.
        base = bv_cnt;
        c0   = brst_cnt;
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        slot(200, 1);
        brst_low = low_cyc;
        settle();
        check("brst_count", brst_cnt - c0, 1);
        check("brst_timing", brst_cyc - brst_low, 119 + LAT);
        check("brst_no_bit", bv_cnt - base, 3);
        check("brst_keeps_valid", byte_valid, 1'b1);
        check("brst_keeps_data", byte_data, 8'h5A);
        ack_byte("brst_ack");
        send_byte(8'h81);
        settle();
        check("after_brst_byte", byte_data, 8'h81);
        check("after_brst_valid", byte_valid, 1'b1);

        // Async reset during the 30th cycle of a 60-cycle low.
        base   = bv_cnt;
        bus_in = 1'b0;
        repeat (29) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_outputs",
              {bit_valid, bit_data, byte_valid, byte_data, overrun, glitch, bus_reset}, 0);
        @(negedge clk);
        repeat (30) @(negedge clk);
        bus_in = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("async_rst_no_bit", bv_cnt - base, 0);
        base = bv_cnt;
        c0   = ovr_cnt;
        send_byte(8'h96);
        settle();
        check("after_rst_bits", rx_byte(base), 8'h96);
        check("after_rst_byte", byte_data, 8'h96);
        check("after_rst_valid", byte_valid, 1'b1);
        check("after_rst_no_overrun", ovr_cnt - c0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
